inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 74 +++++++
 tb/tb_inst_fetch.sv | 134 +++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: single-outstanding instruction fetch stage with redirect handling.
// Optional macro IF_MISALIGN_CHECK_EN enables the sticky misaligned-redirect fault.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] INST,
    output logic [31:0] PC_OUT,
    output logic        inst_valid,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {REQ, WAIT, HOLD, DROP} state_t;
    state_t state, state_d;
    logic [31:0] pc, pc_d, inst_d, pc_out_d, target;
    logic fault, fault_d, bad;
`ifdef IF_MISALIGN_CHECK_EN
    assign target = redirect_pc;
    assign bad = redirect_pc[1:0] != 2'b00;
`else
    assign target = redirect_pc & ~32'h3;
    assign bad = 1'b0;
`endif
    assign imem_req_valid = state == REQ && !redirect && !fault && !rst;
    assign inst_valid = state == HOLD && !fault && !rst;
    assign imem_addr = pc;
    assign fetch_fault = fault;
    always_comb begin
        state_d = state;
        pc_d = pc;
        inst_d = INST;
        pc_out_d = PC_OUT;
        fault_d = fault | (redirect & bad);
        if (redirect) begin
            pc_d = target;
            state_d = state == WAIT ? (imem_rsp_valid ? REQ : DROP) : state == DROP ? DROP : REQ;
        end else begin
            unique case (state)
                REQ: if (imem_req_valid && imem_req_ready) state_d = WAIT;
                WAIT: if (imem_rsp_valid) begin
                    state_d = HOLD;
                    inst_d = imem_rsp_data;
                    pc_out_d = pc;
                    pc_d = pc + 32'd4;
                end
                HOLD: if (id_ready) state_d = REQ;
                DROP: if (imem_rsp_valid) state_d = REQ;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc <= RESET_PC;
            INST <= 32'h0000_0013;
            PC_OUT <= 32'h0;
            fault <= 1'b0;
        end else begin
            state <= state_d;
            pc <= pc_d;
            INST <= inst_d;
            PC_OUT <= pc_out_d;
            fault <= fault_d;
        end
    end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed scenarios plus randomized traffic checked against a
// transaction-level model of the fetch stage.
module tb_inst_fetch;
`ifdef IF_MISALIGN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
    logic [31:0] imem_addr, imem_rsp_data = 32'h0, INST, PC_OUT, redirect_pc = 32'h0;
    logic inst_valid, id_ready = 1'b0, redirect = 1'b0, fetch_fault;
    int checks = 0, errors = 0;
    // model: outstanding request, response to discard, instruction held for decode
    logic m_out, m_drop, m_hold, m_fault, exp_rv;
    logic [31:0] m_pc, m_inst, m_pcout;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .INST(INST), .PC_OUT(PC_OUT), .inst_valid(inst_valid), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_out = 0; m_drop = 0; m_hold = 0; m_fault = 0;
        m_pc = 32'h0; m_inst = 32'h0000_0013; m_pcout = 32'h0;
    endtask

    task automatic step(input logic r, input logic rdy, input logic rv, input logic [31:0] d,
                        input logic idr, input logic rd, input logic [31:0] rpc);
        rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
        id_ready = idr; redirect = rd; redirect_pc = rpc;
        @(negedge clk);
        exp_rv = !r && !m_out && !m_drop && !m_hold && !rd && !m_fault;
        check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
        if (exp_rv) check("imem_addr", imem_addr, m_pc);
        check("inst_valid", {31'b0, inst_valid}, {31'b0, !r && m_hold && !m_fault});
        check("inst", INST, m_inst);
        check("pc_out", PC_OUT, m_pcout);
        check("fault", {31'b0, fetch_fault}, {31'b0, m_fault});
        @(posedge clk);
        if (r) model_reset();
        else if (rd) begin
            if (CHK && rpc[1:0] != 2'b00) m_fault = 1;
            m_pc = CHK ? rpc : rpc & ~32'h3;
            m_hold = 0;
            if (m_out) begin m_out = 0; m_drop = !rv; end
        end else if (exp_rv && rdy) m_out = 1;
        else if (m_out && rv) begin
            m_out = 0; m_hold = 1; m_inst = d; m_pcout = m_pc; m_pc = m_pc + 32'd4;
        end else if (m_hold && idr) m_hold = 0;
        else if (m_drop && rv) m_drop = 0;
        #1;
    endtask

    task automatic fetch(input logic [31:0] d);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, d, 0, 0, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_inst", INST, 32'h0000_0013);
        check("rst_pc_out", PC_OUT, 32'h0);
        step(0, 1, 0, 0, 0, 0, 0);
        check("first_addr_state", {31'b0, imem_req_valid}, 32'h0);
        step(0, 1, 1, 32'h0010_0093, 0, 0, 0);
        check("first_inst", INST, 32'h0010_0093);
        check("first_pc_out", PC_OUT, 32'h0);
        check("first_valid", {31'b0, inst_valid}, 32'h1);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 32'hDEAD_BEEF, 0, 0, 0);
        check("hold_inst", INST, 32'h0010_0093);
        check("hold_noreq", {31'b0, imem_req_valid}, 32'h0);
        step(0, 1, 0, 0, 1, 0, 0);
        check("next_addr", imem_addr, 32'h4);
        check("next_reqv", {31'b0, imem_req_valid}, 32'h1);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1, 32'h100);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);
        check("drop_valid", {31'b0, inst_valid}, 32'h0);
        check("drop_addr", imem_addr, 32'h100);
        check("drop_reqv", {31'b0, imem_req_valid}, 32'h1);
        fetch(32'h1111_1111);
        step(0, 0, 0, 0, 1, 1, 32'h200);
        check("squash_valid", {31'b0, inst_valid}, 32'h0);
        check("squash_addr", imem_addr, 32'h200);
        step(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        fetch(32'h2222_2222);
        check("wrap_pc1", PC_OUT, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, 0, 0);
        fetch(32'h3333_3333);
        check("wrap_pc2", PC_OUT, 32'h0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h102);
        if (CHK) begin
            check("mis_fault", {31'b0, fetch_fault}, 32'h1);
            step(0, 1, 0, 0, 1, 0, 0);
            check("mis_noreq", {31'b0, imem_req_valid}, 32'h0);
        end else begin
            check("mis_addr", imem_addr, 32'h100);
        end
        step(1, 0, 0, 0, 0, 0, 0);
        check("rst_fault", {31'b0, fetch_fault}, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            logic r, rd;
            logic [31:0] rpc;
            r = ($urandom_range(0, 199) == 0) || (m_fault && $urandom_range(0, 19) == 0);
            rd = $urandom_range(0, 9) == 0;
            rpc = $urandom & ~32'h3;
            if ($urandom_range(0, 19) == 0) rpc = 32'hFFFF_FFF8;
            if ($urandom_range(0, 29) == 0) rpc = $urandom;
            step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom,
                 1'($urandom_range(0, 1)), rd, rpc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
